// File: rtl/snake_body_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : snake_body_ctrl
//  Purpose  : Snake body segment store with move, grow, wall and self-hit FSM.
//  Revision : 1.0
// ============================================================================
module snake_body_ctrl #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int CELL     = 10,
    parameter int START_X  = 320,
    parameter int START_Y  = 240,
    parameter int X_MAX    = 630,
    parameter int Y_MAX    = 470
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   move_tick,
    input  logic [1:0]             dir_in,
    input  logic                   grow,
    output logic [MAX_LEN*11-1:0]  part_x,
    output logic [MAX_LEN*11-1:0]  part_y,
    output logic [MAX_LEN-1:0]     part_active,
    output logic [5:0]             length,
    output logic                   busy,
    output logic                   done,
    output logic                   dead
);

    localparam int          IDX_W       = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
    localparam logic [1:0]  c_DIR_RIGHT = 2'b00;
    localparam logic [1:0]  c_DIR_DOWN  = 2'b01;
    localparam logic [1:0]  c_DIR_LEFT  = 2'b10;
    localparam logic [10:0] c_CELL      = 11'(CELL);
    localparam logic [11:0] c_X_MAX     = 12'(X_MAX);
    localparam logic [11:0] c_Y_MAX     = 12'(Y_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_done_nxt;
    logic               r_done;
    logic [1:0]         r_dir;
    logic               r_grow;
    logic [5:0]         r_len;
    logic [5:0]         r_idx;
    logic [10:0]        r_seg_x [MAX_LEN];
    logic [10:0]        r_seg_y [MAX_LEN];

    logic [10:0]        w_head_nx;
    logic [10:0]        w_head_ny;
    logic               w_wall;
    logic               w_hit;
    logic               w_last;
    logic               w_reverse;
    logic [IDX_W-1:0]   w_idx;

    // Wall test is done one bit wider so the right/down sum can never wrap.
    always_comb begin
        w_head_nx = r_seg_x[0];
        w_head_ny = r_seg_y[0];
        w_wall    = 1'b0;
        case (r_dir)
            c_DIR_RIGHT: begin
                w_wall    = ({1'b0, r_seg_x[0]} + {1'b0, c_CELL}) > c_X_MAX;
                w_head_nx = r_seg_x[0] + c_CELL;
            end
            c_DIR_DOWN: begin
                w_wall    = ({1'b0, r_seg_y[0]} + {1'b0, c_CELL}) > c_Y_MAX;
                w_head_ny = r_seg_y[0] + c_CELL;
            end
            c_DIR_LEFT: begin
                w_wall    = r_seg_x[0] < c_CELL;
                w_head_nx = r_seg_x[0] - c_CELL;
            end
            default: begin
                w_wall    = r_seg_y[0] < c_CELL;
                w_head_ny = r_seg_y[0] - c_CELL;
            end
        endcase
    end

    assign w_idx     = r_idx[IDX_W-1:0];
    assign w_hit     = (r_seg_x[w_idx] == r_seg_x[0]) && (r_seg_y[w_idx] == r_seg_y[0]);
    assign w_last    = (r_idx == (r_len - 6'd1));
    assign w_reverse = ((dir_in ^ r_dir) == 2'b10);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE:  if (move_tick) w_state_nxt = S_SHIFT;
            S_SHIFT: w_state_nxt = w_wall ? S_DEAD : S_CHECK;
            S_CHECK: begin
                if (w_hit) begin
                    w_state_nxt = S_DEAD;
                end else if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            S_DEAD:  w_state_nxt = S_DEAD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir  <= c_DIR_RIGHT;
            r_grow <= 1'b0;
            r_len  <= 6'(INIT_LEN);
            r_idx  <= 6'd1;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= (i < INIT_LEN) ? 11'(START_X - i * CELL) : 11'd0;
                r_seg_y[i] <= (i < INIT_LEN) ? 11'(START_Y) : 11'd0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (move_tick) begin
                        if (!w_reverse) r_dir <= dir_in;
                        r_grow <= grow;
                    end
                end
                S_SHIFT: begin
                    if (!w_wall) begin
                        for (int i = MAX_LEN - 1; i >= 1; i--) begin
                            r_seg_x[i] <= r_seg_x[i-1];
                            r_seg_y[i] <= r_seg_y[i-1];
                        end
                        r_seg_x[0] <= w_head_nx;
                        r_seg_y[0] <= w_head_ny;
                        r_idx      <= 6'd1;
                        if (r_grow && (r_len < 6'(MAX_LEN))) r_len <= r_len + 6'd1;
                    end
                end
                S_CHECK: r_idx <= r_idx + 6'd1;
                default: ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_pack
            assign part_x[11*gi +: 11] = r_seg_x[gi];
            assign part_y[11*gi +: 11] = r_seg_y[gi];
            assign part_active[gi]     = (6'(gi) < r_len);
        end
    endgenerate

    assign length = r_len;
    assign busy   = (r_state == S_SHIFT) || (r_state == S_CHECK);
    assign dead   = (r_state == S_DEAD);
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_snake_body_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snake_body_ctrl
//  Purpose  : Randomized and directed bench for snake_body_ctrl with a model.
//  Revision : 1.0
// ============================================================================
module tb_snake_body_ctrl;

    localparam int MAX_LEN  = 16;
    localparam int INIT_LEN = 3;
    localparam int CELL     = 10;
    localparam int SX       = 320;
    localparam int SY       = 240;
    localparam int XM       = 630;
    localparam int YM       = 470;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  move_tick;
    logic [1:0]            dir_in;
    logic                  grow;
    logic [MAX_LEN*11-1:0] part_x;
    logic [MAX_LEN*11-1:0] part_y;
    logic [MAX_LEN-1:0]    part_active;
    logic [5:0]            length;
    logic                  busy;
    logic                  done;
    logic                  dead;

    snake_body_ctrl #(
        .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .CELL(CELL),
        .START_X(SX), .START_Y(SY), .X_MAX(XM), .Y_MAX(YM)
    ) dut (
        .clk(clk), .rst(rst), .move_tick(move_tick), .dir_in(dir_in), .grow(grow),
        .part_x(part_x), .part_y(part_y), .part_active(part_active),
        .length(length), .busy(busy), .done(done), .dead(dead)
    );

    always #20 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference snake: coordinates as plain integers, slot 0 is the head.
    int mx [MAX_LEN];
    int my [MAX_LEN];
    int mlen;
    int mdir;
    bit mdead;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < MAX_LEN; i++) begin
            mx[i] = (i < INIT_LEN) ? SX - i * CELL : 0;
            my[i] = (i < INIT_LEN) ? SY : 0;
        end
        mlen  = INIT_LEN;
        mdir  = 0;
        mdead = 0;
    endfunction

    // Returns the observation index (negedges after the sampling edge) at
    // which the move finishes, with exp_dead telling how it finishes.
    function automatic int model_move(input int d, input bit g, output bit exp_dead);
        int nx, ny;
        exp_dead = 0;
        if (((d - mdir + 4) % 4) != 2) mdir = d;
        nx = mx[0];
        ny = my[0];
        case (mdir)
            0: nx = nx + CELL;
            1: ny = ny + CELL;
            2: nx = nx - CELL;
            default: ny = ny - CELL;
        endcase
        if (nx < 0 || nx > XM || ny < 0 || ny > YM) begin
            mdead = 1; exp_dead = 1;
            return 2;
        end
        for (int i = MAX_LEN - 1; i >= 1; i--) begin
            mx[i] = mx[i-1];
            my[i] = my[i-1];
        end
        mx[0] = nx;
        my[0] = ny;
        if (g && mlen < MAX_LEN) mlen++;
        for (int j = 1; j < mlen; j++) begin
            if (mx[j] == mx[0] && my[j] == my[0]) begin
                mdead = 1; exp_dead = 1;
                return j + 2;
            end
        end
        return mlen + 1;
    endfunction

    task automatic check_state(input bit all_slots);
        logic [MAX_LEN-1:0] act;
        for (int i = 0; i < MAX_LEN; i++) act[i] = (i < mlen);
        check("length", length, mlen);
        check("part_active", part_active, act);
        check("busy", busy, 0);
        check("dead", dead, mdead);
        for (int i = 0; i < MAX_LEN; i++) begin
            if (all_slots || i < mlen) begin
                check("seg_x", part_x[11*i +: 11], mx[i]);
                check("seg_y", part_y[11*i +: 11], my[i]);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; move_tick = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        check("reset_done", done, 0);
        check_state(1);
    endtask

    task automatic do_move(input int d, input bit g, input bit noise);
        int  end_n;
        bit  exp_dead;
        @(negedge clk);
        move_tick = 1; dir_in = 2'(d); grow = g;
        if (mdead) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                move_tick = 0;
                check("dead_done", done, 0);
                check("dead_hold", dead, 1);
            end
            check_state(0);
            return;
        end
        end_n = model_move(d, g, exp_dead);
        @(posedge clk);
        for (int n = 1; n <= end_n; n++) begin
            @(negedge clk);
            check("done", done, (!exp_dead && n == end_n));
            check("dead", dead, (exp_dead && n == end_n));
            check("busy", busy, (n < end_n));
            move_tick = (noise && n == 2);
        end
        @(negedge clk);
        move_tick = 0;
        check("done_pulse", done, 0);
        check_state(0);
    endtask

    initial begin
        rst = 1; move_tick = 0; dir_in = 0; grow = 0;
        repeat (3) @(posedge clk);
        do_reset();

        // Plain right move, then a reversal attempt from reset.
        do_move(0, 0, 0);
        check("head_x_right", part_x[10:0], 330);
        do_reset();
        do_move(2, 0, 0);
        check("head_x_reverse", part_x[10:0], 330);

        // Growth up to and past MAX_LEN, then run into the right wall.
        do_reset();
        do_move(0, 1, 0);
        check("active_after_grow", part_active, 16'h000F);
        check("seg3_x", part_x[43:33], 300);
        for (int k = 0; k < 13; k++) do_move(0, 1, 0);
        check("len_saturated", length, 16);
        for (int k = 0; k < 40 && !mdead; k++) do_move(0, 0, 1);
        check("wall_dead", dead, 1);
        check("wall_head_x", part_x[10:0], 630);
        do_move(0, 0, 0);

        // Self collision: length 5, then down, left, up.
        do_reset();
        do_move(0, 1, 0);
        do_move(0, 1, 0);
        do_move(1, 0, 0);
        do_move(2, 0, 0);
        do_move(3, 0, 0);
        check("self_dead", dead, 1);

        // Reset landing in the SHIFT cycle aborts the move.
        do_reset();
        @(negedge clk);
        move_tick = 1; dir_in = 0; grow = 0;
        @(posedge clk);
        @(negedge clk);
        move_tick = 0; rst = 1;
        check("abort_done", done, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        check_state(1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        check_state(1);

        // Random walk; each death is probed once and then reset.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            do_move(int'($urandom % 4), ($urandom % 4) == 0, bit'($urandom % 2));
            if (mdead) begin
                do_move(int'($urandom % 4), 0, 0);
                do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
